// File: rtl/fixed_point_div_pkg.sv
// ============================================================================
// Module      : fixed_point_div_pkg
// Description : Shared types and sizing helpers for the unsigned fixed-point
//               restoring long divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fixed_point_div_pkg;

  // Controller states; width is explicit so the encoding is fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Number of restoring iterations: one per bit of (dividend << FRAC).
  function automatic int iter_count(input int width, input int frac);
    return width + frac;
  endfunction

  // Counter width large enough to hold the iteration count itself.
  function automatic int cnt_width(input int width, input int frac);
    return $clog2(iter_count(width, frac) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/restoring_div_step.sv
// ============================================================================
// Module      : restoring_div_step
// Description : One combinational restoring-division step. The partial
//               remainder is shifted left with the next numerator bit. The
//               divisor is subtracted if it fits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  // One extra bit of headroom so the shifted remainder never wraps.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  // Shift in the next bit, then trial-subtract and restore when it does not fit.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_divisor};
    w_fits  = (w_shift >= {2'b00, i_divisor});
    o_qbit  = w_fits;
    o_rem   = w_fits ? (WIDTH+1)'(w_diff) : (WIDTH+1)'(w_shift);
  end

endmodule

`default_nettype wire

// File: rtl/fixed_point_unsigned_long_divider.sv
// ============================================================================
// Module      : fixed_point_unsigned_long_divider
// Description : Sequential unsigned Q(WIDTH-FRAC).FRAC divider. Produces one
//               quotient bit per clock with a valid/ready handshake on both
//               sides. Reports remainder, saturation overflow and divide-by-
//               zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_unsigned_long_divider
  import fixed_point_div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_overflow,
  output logic             o_div_by_zero
);

  localparam int c_iter_n = iter_count(WIDTH, FRAC);
  localparam int c_cnt_w  = cnt_width(WIDTH, FRAC);

  div_state_e         r_state;
  div_state_e         w_state_next;

  logic [c_iter_n-1:0] r_num;        // numerator, consumed MSB first by shifting
  logic [c_iter_n-1:0] r_quot;       // raw quotient bits collected so far
  logic [WIDTH:0]      r_rem;        // partial remainder
  logic [WIDTH-1:0]    r_divisor;
  logic [c_cnt_w-1:0]  r_cnt;        // iterations remaining

  logic [WIDTH-1:0]    r_quotient;
  logic [WIDTH-1:0]    r_remainder;
  logic                r_overflow;
  logic                r_div_by_zero;

  logic [WIDTH:0]      w_rem_next;
  logic                w_qbit;
  logic [c_iter_n-1:0] w_raw_quot;
  logic                w_sat;
  logic [WIDTH-1:0]    w_quot_out;
  logic                w_last;

  restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_num[c_iter_n-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Full raw quotient as it will look once this step's bit is appended.
  assign w_raw_quot = c_iter_n'({r_quot, w_qbit});

  // Saturate when any integer bit beyond the output width is set.
  if (FRAC > 0) begin : g_sat
    assign w_sat = |w_raw_quot[c_iter_n-1:WIDTH];
  end else begin : g_no_sat
    assign w_sat = 1'b0;
  end

  assign w_quot_out = w_sat ? {WIDTH{1'b1}} : w_raw_quot[WIDTH-1:0];
  assign w_last     = (r_state == BUSY) && (r_cnt == c_cnt_w'(1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_state_next = (i_divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == c_cnt_w'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; results come from holding registers.
  always_comb begin
    o_ready       = (r_state == IDLE);
    o_valid       = (r_state == DONE);
    o_quotient    = r_quotient;
    o_remainder   = r_remainder;
    o_overflow    = r_overflow;
    o_div_by_zero = r_div_by_zero;
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_num         <= '0;
      r_quot        <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (r_state == IDLE && i_valid) begin
      if (i_divisor != '0) begin
        r_num     <= c_iter_n'(i_dividend) << FRAC;
        r_divisor <= i_divisor;
        r_rem     <= '0;
        r_quot    <= '0;
        r_cnt     <= c_cnt_w'(c_iter_n);
      end else begin
        r_quotient    <= {WIDTH{1'b1}};
        r_remainder   <= '0;
        r_overflow    <= 1'b0;
        r_div_by_zero <= 1'b1;
      end
    end else if (r_state == BUSY) begin
      r_rem  <= w_rem_next;
      r_num  <= r_num << 1;
      r_quot <= w_raw_quot;
      r_cnt  <= r_cnt - c_cnt_w'(1);
      if (w_last) begin
        r_quotient    <= w_quot_out;
        r_remainder   <= w_rem_next[WIDTH-1:0];
        r_overflow    <= w_sat;
        r_div_by_zero <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_unsigned_long_divider.sv
// ============================================================================
// Module      : tb_fixed_point_unsigned_long_divider
// Description : Directed, table-driven bench for the fixed-point divider
//               (WIDTH=8, FRAC=4) with hand-written backpressure and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_point_unsigned_long_divider;

  localparam int WIDTH   = 8;
  localparam int FRAC    = 4;
  localparam int LAT     = WIDTH + FRAC;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dbz;
  } vec_t;

  vec_t vecs[14];

  fixed_point_unsigned_long_divider #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_valid       (in_valid),
    .o_ready       (out_ready),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_valid       (out_valid),
    .i_ready       (in_ready),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_overflow    (overflow),
    .o_div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for exactly one accepting edge; returns after that edge (+1).
  task automatic start_div(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until o_valid, bounded.
  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string name, input vec_t v);
    chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, " ready"}, {31'd0, out_ready}, 32'd0);
    chk({name, " quotient"}, {24'd0, quotient}, {24'd0, v.q});
    chk({name, " remainder"}, {24'd0, remainder}, {24'd0, v.r});
    chk({name, " overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " valid after consume"}, {31'd0, out_valid}, 32'd0);
    chk({name, " ready after consume"}, {31'd0, out_ready}, 32'd1);
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  initial begin
    vec_t bp;
    // dividend, divisor -> quotient, remainder, overflow, div_by_zero
    vecs[0]  = '{8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0};  // 3.0/2.0 = 1.5
    vecs[1]  = '{8'h10, 8'h30, 8'h05, 8'h10, 1'b0, 1'b0};  // 1.0/3.0 truncated
    vecs[2]  = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0};  // 4080 -> saturate
    vecs[3]  = '{8'h40, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};  // divide by zero
    vecs[4]  = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};  // zero dividend
    vecs[5]  = '{8'h01, 8'hFF, 8'h00, 8'h10, 1'b0, 1'b0};  // 16/255
    vecs[6]  = '{8'hFF, 8'hFF, 8'h10, 8'h00, 1'b0, 1'b0};  // x/x = 1.0
    vecs[7]  = '{8'h0F, 8'h01, 8'hF0, 8'h00, 1'b0, 1'b0};  // 240, just fits
    vecs[8]  = '{8'h10, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0};  // 256, first overflow
    vecs[9]  = '{8'h80, 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0};  // 2048/8 = 256
    vecs[10] = '{8'h7F, 8'h08, 8'hFE, 8'h00, 1'b0, 1'b0};  // 2032/8 = 254
    vecs[11] = '{8'hFF, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b0};  // 255 exactly, no overflow
    vecs[12] = '{8'h64, 8'h07, 8'hE4, 8'h04, 1'b0, 1'b0};  // 1600/7 = 228 r 4
    vecs[13] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};  // 0/0 still div-by-zero

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, out_ready}, 32'd1);
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset quotient", {24'd0, quotient}, 32'd0);
    chk("reset remainder", {24'd0, remainder}, 32'd0);
    chk("reset flags", {30'd0, overflow, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_div(vecs[i].dvd, vecs[i].dvs);
      wait_valid(nm, vecs[i].dbz ? 0 : LAT);
      check_result(nm, vecs[i]);
      consume(nm);
    end

    // Backpressure: result held, new requests ignored
    bp = '{8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0};
    start_div(bp.dvd, bp.dvs);
    wait_valid("bp", LAT);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dividend = 8'hFF;
      divisor  = 8'h01;
      in_valid = (c % 2 == 0);
      @(posedge clk);
      #1;
      check_result($sformatf("bp hold%0d", c), bp);
    end
    in_valid = 1'b0;
    consume("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp nothing queued", {31'd0, out_valid}, 32'd0);
    chk("bp idle", {31'd0, out_ready}, 32'd1);

    // Reset mid-BUSY discards the in-flight division
    start_div(8'h10, 8'h30);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst ready", {31'd0, out_ready}, 32'd1);
    chk("midrst valid", {31'd0, out_valid}, 32'd0);
    chk("midrst quotient", {24'd0, quotient}, 32'd0);
    chk("midrst remainder", {24'd0, remainder}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("midrst no result", {31'd0, out_valid}, 32'd0);
    start_div(bp.dvd, bp.dvs);
    wait_valid("after rst", LAT);
    check_result("after rst", bp);

    // Reset while DONE clears the held result and flags
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("donerst valid", {31'd0, out_valid}, 32'd0);
    chk("donerst quotient", {24'd0, quotient}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
